// File: rtl/lava_pkg.sv
// Shared fixed-point types, FSM states and the wall-bounce helper for the metaball evaluator.
package lava_pkg;

  typedef logic signed [31:0] fix_t;

  localparam int          FRAC_BITS = 16;
  localparam logic [31:0] FIX_ONE   = 32'h0001_0000;
  localparam logic [31:0] FIX_MAX   = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {IDLE, DIFF, SQR, SUM, DIV, OUT} mb_state_t;

  typedef struct packed {
    fix_t pos;
    logic flip;
  } mv_t;

  // Clamp a 51-bit distance to the 32-bit divisor range.
  function automatic logic [31:0] sat_u32(input logic [50:0] v);
    return (|v[50:32]) ? FIX_MAX : v[31:0];
  endfunction

  // One movement step on one axis; the sum is done 33 bits wide so it cannot wrap.
  function automatic mv_t bounce(input fix_t c, input fix_t v, input fix_t mn, input fix_t mx);
    logic signed [32:0] n;
    logic signed [32:0] lo;
    logic signed [32:0] hi;
    mv_t r;
    n  = {c[31], c} + {v[31], v};
    lo = {mn[31], mn};
    hi = {mx[31], mx};
    if (n > hi) begin
      r.pos  = mx;
      r.flip = 1'b1;
    end else if (n < lo) begin
      r.pos  = mn;
      r.flip = 1'b1;
    end else begin
      r.pos  = n[31:0];
      r.flip = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/fix_div.sv
// 48-bit by 32-bit restoring divider, one quotient bit per cycle MSB first.
// done pulses 48 cycles after start; a start while busy restarts the division.
module fix_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [47:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [47:0] quotient
);

  logic [31:0] r_rem;
  logic [31:0] r_dvs;
  logic [47:0] r_quo;
  logic [5:0]  r_cnt;
  logic        r_busy;
  logic        r_done;

  logic [32:0] w_rem_sh;
  logic [31:0] w_diff;
  logic        w_ge;

  // Dividend bits shift out of r_quo's top as quotient bits shift into its bottom.
  assign w_rem_sh = {r_rem, r_quo[47]};
  assign w_ge     = (w_rem_sh >= {1'b0, r_dvs});
  assign w_diff   = w_rem_sh[31:0] - r_dvs;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rem  <= '0;
      r_dvs  <= '0;
      r_quo  <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_rem  <= '0;
        r_dvs  <= divisor;
        r_quo  <= dividend;
        r_cnt  <= 6'd47;
        r_busy <= 1'b1;
      end else if (r_busy) begin
        r_rem <= w_ge ? w_diff : w_rem_sh[31:0];
        r_quo <= {r_quo[46:0], w_ge};
        r_cnt <= r_cnt - 6'd1;
        if (r_cnt == 6'd0) begin
          r_busy <= 1'b0;
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign quotient = r_quo;

endmodule

// File: rtl/metaball_eval.sv
// Field of one bouncing metaball, f = R2 / |p - c|^2 in Q16.16, 52-cycle fixed latency.
// Strobes arriving while busy are dropped; movement runs independently of the evaluation.
module metaball_eval
  import lava_pkg::*;
#(
  parameter fix_t        X0    = 32'h0004_0000,
  parameter fix_t        Y0    = 32'h0004_0000,
  parameter fix_t        VX0   = 32'h0000_1000,
  parameter fix_t        VY0   = 32'h0000_0800,
  parameter logic [31:0] R2    = 32'h0001_0000,
  parameter fix_t        X_MIN = 32'h0000_0000,
  parameter fix_t        X_MAX = 32'h000F_8000,
  parameter fix_t        Y_MIN = 32'h0000_0000,
  parameter fix_t        Y_MAX = 32'h000F_C000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mov_en,
  input  logic        px_stb,
  input  logic [31:0] p_x,
  input  logic [31:0] p_y,
  output logic        vld,
  output logic [31:0] out
);

  mb_state_t r_state;
  mb_state_t w_next;

  fix_t r_cx, r_cy, r_vx, r_vy;
  fix_t r_snap_px, r_snap_py, r_snap_cx, r_snap_cy;

  logic signed [32:0] r_dx, r_dy;
  logic [65:0]        r_sx, r_sy;
  logic [31:0]        r_d2;
  logic [31:0]        r_out;

  logic signed [65:0] w_dx_ext, w_dy_ext, w_sqx, w_sqy;
  logic [66:0]        w_sum;
  logic [31:0]        w_d2;
  logic               w_div_start;
  logic               w_div_busy;
  logic               w_div_done;
  logic [47:0]        w_quo;
  mv_t                w_mx, w_my;

  assign w_dx_ext = {{33{r_dx[32]}}, r_dx};
  assign w_dy_ext = {{33{r_dy[32]}}, r_dy};
  assign w_sqx    = w_dx_ext * w_dx_ext;
  assign w_sqy    = w_dy_ext * w_dy_ext;
  assign w_sum    = {1'b0, r_sx} + {1'b0, r_sy};
  assign w_d2     = sat_u32(w_sum[66:16]);

  fix_div u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (w_div_start),
    .dividend ({R2, 16'h0000}),
    .divisor  (w_d2),
    .busy     (w_div_busy),
    .done     (w_div_done),
    .quotient (w_quo)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_div_start = 1'b0;
    case (r_state)
      IDLE: if (px_stb) w_next = DIFF;
      DIFF: w_next = SQR;
      SQR:  w_next = SUM;
      SUM: begin
        w_div_start = 1'b1;
        w_next      = DIV;
      end
      DIV:  if (w_div_done && !w_div_busy) w_next = OUT;
      OUT:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snap_px <= '0;
      r_snap_py <= '0;
      r_snap_cx <= '0;
      r_snap_cy <= '0;
      r_dx      <= '0;
      r_dy      <= '0;
      r_sx      <= '0;
      r_sy      <= '0;
      r_d2      <= '0;
      r_out     <= '0;
    end else begin
      case (r_state)
        IDLE: if (px_stb) begin
          // Centre is frozen here so a concurrent mov_en cannot disturb this evaluation.
          r_snap_px <= p_x;
          r_snap_py <= p_y;
          r_snap_cx <= r_cx;
          r_snap_cy <= r_cy;
        end
        DIFF: begin
          r_dx <= {r_snap_px[31], r_snap_px} - {r_snap_cx[31], r_snap_cx};
          r_dy <= {r_snap_py[31], r_snap_py} - {r_snap_cy[31], r_snap_cy};
        end
        SQR: begin
          r_sx <= w_sqx;
          r_sy <= w_sqy;
        end
        SUM: r_d2 <= w_d2;
        DIV: if (w_next == OUT)
          r_out <= ((r_d2 == 32'd0) || (|w_quo[47:32])) ? FIX_MAX : w_quo[31:0];
        default: ;
      endcase
    end
  end

  assign w_mx = bounce(r_cx, r_vx, X_MIN, X_MAX);
  assign w_my = bounce(r_cy, r_vy, Y_MIN, Y_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cx <= X0;
      r_cy <= Y0;
      r_vx <= VX0;
      r_vy <= VY0;
    end else if (mov_en) begin
      r_cx <= w_mx.pos;
      r_cy <= w_my.pos;
      if (w_mx.flip) r_vx <= -r_vx;
      if (w_my.flip) r_vy <= -r_vy;
    end
  end

  assign vld = (r_state == OUT);
  assign out = r_out;

endmodule
